// File: rtl/nbit_serial_subtractor_pkg.sv
// Shared definitions for the serial subtractor slice.
// Holds the controller state encoding together with the single-bit
// arithmetic primitives (full adder / full subtractor equations) used
// across the arithmetic blocks of this codebase.
// No ports: this file is a package only.
package nbit_serial_subtractor_pkg;

    // Controller states of the serial subtractor, two-bit encoding.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Full adder sum bit.
    function automatic logic fa_sum(input logic a, input logic b, input logic cin);
        return a ^ b ^ cin;
    endfunction

    // Full adder carry out.
    function automatic logic fa_carry(input logic a, input logic b, input logic cin);
        return (a & b) | ((a ^ b) & cin);
    endfunction

    // Full subtractor difference bit (a - b - bin).
    function automatic logic fs_diff(input logic a, input logic b, input logic bin);
        return a ^ b ^ bin;
    endfunction

    // Full subtractor borrow out: borrow when b exceeds a, or when they
    // are equal and a borrow is already pending.
    function automatic logic fs_borrow(input logic a, input logic b, input logic bin);
        return (~a & b) | (~(a ^ b) & bin);
    endfunction

endpackage

// File: rtl/nbit_serial_subtractor_full_subtractor.sv
// One-bit full subtractor, the per-bit cell of the serial subtractor.
// Mirrors the structure of full_adder: pure combinational gates.
// Ports:
//   A    - minuend bit
//   B    - subtrahend bit
//   Bin  - incoming borrow
//   D    - difference bit
//   Bout - outgoing borrow
module full_subtractor (
    input  logic A,
    input  logic B,
    input  logic Bin,
    output logic D,
    output logic Bout
);

    assign D    = A ^ B ^ Bin;
    assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/nbit_serial_subtractor.sv
// Bit-serial unsigned subtractor computing a - b over N clock cycles,
// LSB first, with optional clamping of an underflowed result to zero.
// Ports:
//   clk        - clock, all state changes on the rising edge
//   rst_n      - synchronous active-low reset
//   start      - request an operation; honoured only when not shifting
//   a, b       - N-bit unsigned minuend / subtrahend, captured on start
//   busy       - high while bits are being processed
//   done       - one-cycle pulse when diff/borrow_out are valid
//   diff       - result (clamped to zero on underflow when SATURATE=1)
//   borrow_out - final borrow, 1 when a < b
module nbit_serial_subtractor
    import nbit_serial_subtractor_pkg::*;
#(
    parameter int N        = 4,
    parameter int SATURATE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow_out
);

    localparam int           CW   = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         state_q, state_d;
    logic [N-1:0]   a_q, a_d;
    logic [N-1:0]   b_q, b_d;
    logic [N-1:0]   res_q, res_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           br_q, br_d;
    logic [N-1:0]   diff_q, diff_d;
    logic           borrow_q, borrow_d;

    logic           d_bit;
    logic           bout_bit;
    logic [N-1:0]   res_shift;

    full_subtractor u_fs (
        .A    (a_q[0]),
        .B    (b_q[0]),
        .Bin  (br_q),
        .D    (d_bit),
        .Bout (bout_bit)
    );

    // New bit enters from the MSB side; the oldest bit falls off the LSB.
    assign res_shift = N'({d_bit, res_q} >> 1);

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        br_d     = br_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    res_d    = '0;
                    cnt_d    = '0;
                    br_d     = 1'b0;
                    diff_d   = '0;
                    borrow_d = 1'b0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                br_d  = bout_bit;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    diff_d   = ((SATURATE != 0) && bout_bit) ? '0 : res_shift;
                    borrow_d = bout_bit;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset wins over everything, so a start seen alongside reset is dropped
    // and an in-flight operation is abandoned without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            br_q     <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            br_q     <= br_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;

endmodule

// File: tb/tb_nbit_serial_subtractor.sv
// Directed self-checking bench for nbit_serial_subtractor, N=4.
// Two instances share all inputs: one clamping (SATURATE=1), one wrapping.
module tb_nbit_serial_subtractor;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;

    logic       busy_s, done_s, bo_s;
    logic [3:0] diff_s;
    logic       busy_w, done_w, bo_w;
    logic [3:0] diff_w;

    int n_checks = 0;
    int n_fail   = 0;

    nbit_serial_subtractor #(.N(4), .SATURATE(1)) dut_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy_s),
        .done       (done_s),
        .diff       (diff_s),
        .borrow_out (bo_s)
    );

    nbit_serial_subtractor #(.N(4), .SATURATE(0)) dut_wrap (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy_w),
        .done       (done_w),
        .diff       (diff_w),
        .borrow_out (bo_w)
    );

    always #5 clk = ~clk;

    // Advance one cycle; inputs are changed and outputs sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic [3:0] av, input logic [3:0] bv);
        start = s;
        a     = av;
        b     = bv;
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0b expected %0b", tag, obs, exp);
        end
    endtask

    task automatic checkVec(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Compare every output of the clamping instance.
    task automatic checkOutput(input string tag, input logic eb, input logic ed,
                               input logic [3:0] ediff, input logic ebo);
        checkBit({tag, ".busy"}, busy_s, eb);
        checkBit({tag, ".done"}, done_s, ed);
        checkVec({tag, ".diff"}, diff_s, ediff);
        checkBit({tag, ".borrow"}, bo_s, ebo);
    endtask

    task automatic checkWrap(input string tag, input logic ed,
                             input logic [3:0] ediff, input logic ebo);
        checkBit({tag, ".wdone"}, done_w, ed);
        checkVec({tag, ".wdiff"}, diff_w, ediff);
        checkBit({tag, ".wborrow"}, bo_w, ebo);
    endtask

    // One complete operation from an idle block, checking every cycle.
    task automatic runOp(input string tag, input logic [3:0] av, input logic [3:0] bv,
                         input logic [3:0] ediff, input logic ebo, input logic [3:0] ewrap);
        applyStimulus(1'b1, av, bv);
        step();
        applyStimulus(1'b0, 4'hx, 4'hx);
        for (int c = 1; c <= 4; c++) begin
            checkOutput($sformatf("%s.c%0d", tag, c), 1'b1, 1'b0, 4'd0, 1'b0);
            step();
        end
        checkOutput({tag, ".c5"}, 1'b0, 1'b1, ediff, ebo);
        checkWrap({tag, ".c5"}, 1'b1, ewrap, ebo);
        step();
        checkOutput({tag, ".c6"}, 1'b0, 1'b0, ediff, ebo);
    endtask

    initial begin
        rst_n = 1'b0;
        applyStimulus(1'b1, 4'd9, 4'd3);
        step();
        step();
        checkOutput("reset", 1'b0, 1'b0, 4'd0, 1'b0);
        checkWrap("reset", 1'b0, 4'd0, 1'b0);
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'd0, 4'd0);
        step();
        checkOutput("idle", 1'b0, 1'b0, 4'd0, 1'b0);

        runOp("9m3", 4'd9, 4'd3, 4'd6, 1'b0, 4'd6);
        runOp("3m9", 4'd3, 4'd9, 4'd0, 1'b1, 4'd10);
        runOp("0m0", 4'd0, 4'd0, 4'd0, 1'b0, 4'd0);
        runOp("15m15", 4'd15, 4'd15, 4'd0, 1'b0, 4'd0);
        runOp("15m0", 4'd15, 4'd0, 4'd15, 1'b0, 4'd15);

        // Start during SHIFT must not disturb the running 8-1.
        applyStimulus(1'b1, 4'd8, 4'd1);
        step();
        applyStimulus(1'b0, 4'd0, 4'd0);
        step();
        applyStimulus(1'b1, 4'd0, 4'd5);
        checkOutput("ign.c2", 1'b1, 1'b0, 4'd0, 1'b0);
        step();
        applyStimulus(1'b0, 4'd0, 4'd0);
        step();
        step();
        checkOutput("ign.c5", 1'b0, 1'b1, 4'd7, 1'b0);
        step();
        checkOutput("ign.c6", 1'b0, 1'b0, 4'd7, 1'b0);

        // Reset mid-operation, with start also high during the reset cycle.
        applyStimulus(1'b1, 4'd9, 4'd3);
        step();
        applyStimulus(1'b0, 4'd0, 4'd0);
        step();
        step();
        rst_n = 1'b0;
        applyStimulus(1'b1, 4'd7, 4'd1);
        step();
        rst_n = 1'b1;
        applyStimulus(1'b0, 4'd0, 4'd0);
        checkOutput("rst.c4", 1'b0, 1'b0, 4'd0, 1'b0);
        for (int c = 5; c <= 7; c++) begin
            step();
            checkOutput($sformatf("rst.c%0d", c), 1'b0, 1'b0, 4'd0, 1'b0);
        end
        runOp("after_rst", 4'd6, 4'd2, 4'd4, 1'b0, 4'd4);

        // Start held high: back-to-back 12-4 then 5-5.
        applyStimulus(1'b1, 4'd12, 4'd4);
        step();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) applyStimulus(1'b1, 4'd5, 4'd5);
            checkOutput($sformatf("b2b.c%0d", c), 1'b1, 1'b0, 4'd0, 1'b0);
            step();
        end
        checkOutput("b2b.c5", 1'b0, 1'b1, 4'd8, 1'b0);
        checkWrap("b2b.c5", 1'b1, 4'd8, 1'b0);
        step();
        applyStimulus(1'b0, 4'd0, 4'd0);
        for (int c = 6; c <= 9; c++) begin
            checkOutput($sformatf("b2b.c%0d", c), 1'b1, 1'b0, 4'd0, 1'b0);
            step();
        end
        checkOutput("b2b.c10", 1'b0, 1'b1, 4'd0, 1'b0);
        step();
        checkOutput("b2b.c11", 1'b0, 1'b0, 4'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
